// File: rtl/alu_system_pipe.sv
// alu_system_pipe: operand-A source mux, single-cycle ALU and registered
// result stage with a valid/ready handshake. br keeps the last consumed result.
// Optional macro ALU_SYSTEM_MUL_EN adds the iterative shift-add signed
// multiply on op 10. Without it, op 10 is reported as illegal.
module alu_system_pipe #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 2,
    parameter int SELW  = 1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NSRC*WIDTH-1:0]   src_a,
    input  logic [SELW-1:0]         src_sel,
    input  logic [WIDTH-1:0]        b,
    input  logic [3:0]              op,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        r,
    output logic                    zero,
    output logic                    ovfl,
    output logic                    illegal,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        br
);

    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SYSTEM_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;
`else
    typedef enum logic {IDLE = 1'b0} state_e;
`endif

    state_e             state_q, state_d;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   sum, diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic               is_mul;
    logic               accept;
    logic               mul_done;
    logic               load;

    logic [WIDTH-1:0]   res_d;
    logic               ovf_d;
    logic               ill_d;
    logic               out_valid_d;

    logic [WIDTH-1:0]   r_q, br_q;
    logic               zero_q, ovfl_q, illegal_q, out_valid_q;

    // Operand-A select and single-cycle ALU evaluation
    always_comb begin
        op_a = src_a[WIDTH-1:0];
        for (int unsigned k = 1; k < NSRC; k++) begin
            if (src_sel == SELW'(k)) op_a = src_a[k*WIDTH +: WIDTH];
        end
        sum     = op_a + b;
        diff    = op_a - b;
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        case (op)
            4'd0: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd2: alu_res = op_a & b;
            4'd3: alu_res = op_a | b;
            4'd4: alu_res = op_a ^ b;
            4'd5: alu_res = ~op_a;
            4'd6: alu_res = op_a << shamt;
            4'd7: alu_res = op_a >> shamt;
            4'd8: alu_res = $signed(op_a) >>> shamt;
            4'd9: alu_res = WIDTH'($signed(op_a) < $signed(b));
`ifdef ALU_SYSTEM_MUL_EN
            4'd10: is_mul = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

`ifdef ALU_SYSTEM_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d, prod;
    logic [WIDTH-1:0]   mplier_q, abs_a, abs_b;
    logic               neg_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    // Magnitudes, next partial sum and signed product of the multiplier
    always_comb begin
        abs_a   = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        abs_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
        acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod    = neg_q ? (~acc_d + 1'b1) : acc_d;
        mul_res = prod[WIDTH-1:0];
        // Fits in WIDTH signed only if the upper half plus sign bit is uniform
        mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end

    assign mul_done = (state_q == MUL) && (cnt_q == SHW'(WIDTH - 1));

    // Shift-add multiply: magnitudes are multiplied, sign applied on the last step
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && is_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            acc_q    <= '0;
            neg_q    <= op_a[WIDTH-1] ^ b[WIDTH-1];
            cnt_q    <= '0;
        end else if (state_q == MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`else
    assign mul_done = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
`ifdef ALU_SYSTEM_MUL_EN
        case (state_q)
            IDLE:    if (accept && is_mul) state_d = MUL;
            MUL:     if (mul_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end

    // FSM outputs: accept only when idle and the result slot can be refilled
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    end

    // Result selection and output-register control
    always_comb begin
        load  = (accept && !is_mul) || mul_done;
        res_d = alu_res;
        ovf_d = alu_ovf;
        ill_d = alu_ill;
`ifdef ALU_SYSTEM_MUL_EN
        if (mul_done) begin
            res_d = mul_res;
            ovf_d = mul_ovf;
            ill_d = 1'b0;
        end
`endif
        out_valid_d = out_valid_q;
        if (load)                          out_valid_d = 1'b1;
        else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end

    // Output register and consumed-result register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            zero_q      <= 1'b0;
            ovfl_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            br_q        <= '0;
        end else begin
            if (load) begin
                r_q       <= res_d;
                zero_q    <= (res_d == '0);
                ovfl_q    <= ovf_d;
                illegal_q <= ill_d;
            end
            out_valid_q <= out_valid_d;
            if (out_valid_q && out_ready) br_q <= r_q;
        end
    end

    assign r         = r_q;
    assign zero      = zero_q;
    assign ovfl      = ovfl_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;
    assign br        = br_q;

endmodule

// File: tb/tb_alu_system_pipe.sv
// Directed bench for alu_system_pipe at WIDTH=16, NSRC=2.
module tb_alu_system_pipe;

    localparam int WIDTH = 16;
    localparam int NSRC  = 2;
    localparam int SELW  = 1;

    logic                  CLK = 1'b0;
    logic                  reset;
    logic [NSRC*WIDTH-1:0] src_a;
    logic [SELW-1:0]       src_sel;
    logic [WIDTH-1:0]      b;
    logic [3:0]            op;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      r;
    logic                  zero, ovfl, illegal, out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      br;

    int checks = 0;
    int errors = 0;

    alu_system_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .CLK(CLK), .reset(reset), .src_a(src_a), .src_sel(src_sel), .b(b),
        .op(op), .in_valid(in_valid), .in_ready(in_ready), .r(r), .zero(zero),
        .ovfl(ovfl), .illegal(illegal), .out_valid(out_valid),
        .out_ready(out_ready), .br(br)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request and hold it until the accepting edge has passed
    task automatic issue(input logic sel, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] bv, input logic [3:0] opv);
        int n = 0;
        src_sel  = sel;
        src_a    = {a1, a0};
        b        = bv;
        op       = opv;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] er, input logic ez,
                                input logic eo, input logic ei);
        check_eq({name, ".valid"},   32'(out_valid), 32'd1);
        check_eq({name, ".r"},       32'(r),         32'(er));
        check_eq({name, ".zero"},    32'(zero),      32'(ez));
        check_eq({name, ".ovfl"},    32'(ovfl),      32'(eo));
        check_eq({name, ".illegal"}, 32'(illegal),   32'(ei));
        consume();
        check_eq({name, ".br"},      32'(br),        32'(er));
        check_eq({name, ".drop"},    32'(out_valid), 32'd0);
    endtask

    task automatic op_case(input string name, input logic sel, input logic [15:0] a0,
                           input logic [15:0] a1, input logic [15:0] bv, input logic [3:0] opv,
                           input logic [15:0] er, input logic ez, input logic eo, input logic ei);
        issue(sel, a0, a1, bv, opv);
        check_result(name, er, ez, eo, ei);
    endtask

`ifdef ALU_SYSTEM_MUL_EN
    task automatic mul_case(input string name, input logic [15:0] av, input logic [15:0] bv,
                            input logic [15:0] er, input logic ez, input logic eo);
        int n = 0;
        logic rdy_seen = 1'b0;
        issue(1'b0, av, 16'h0000, bv, 4'd10);
        while (!out_valid && n < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            n++;
        end
        check_eq({name, ".latency"}, 32'(n), 32'd16);
        check_eq({name, ".busy"},    32'(rdy_seen), 32'd0);
        check_result(name, er, ez, eo, 1'b0);
    endtask
`endif

    initial begin
        reset     = 1'b0;
        src_a     = '0;
        src_sel   = '0;
        b         = '0;
        op        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();

        check_eq("rst.r",        32'(r),         32'h0);
        check_eq("rst.br",       32'(br),        32'h0);
        check_eq("rst.zero",     32'(zero),      32'h0);
        check_eq("rst.ovfl",     32'(ovfl),      32'h0);
        check_eq("rst.illegal",  32'(illegal),   32'h0);
        check_eq("rst.valid",    32'(out_valid), 32'h0);
        reset = 1'b1;
        #1;
        check_eq("rst.in_ready", 32'(in_ready),  32'h1);

        op_case("add_ovf",  1'b1, 16'h0000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op_case("sub_zero", 1'b0, 16'h0005, 16'h1234, 16'h0005, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Backpressure: result held while out_ready is low, next request waits
        issue(1'b0, 16'hF0F0, 16'h0000, 16'h0FF0, 4'd2);
        check_eq("bp.r",        32'(r),        32'h00F0);
        check_eq("bp.in_ready", 32'(in_ready), 32'h0);
        src_a = {16'h0000, 16'h0001}; b = 16'h0002; op = 4'd3; in_valid = 1'b1;
        repeat (3) tick();
        check_eq("bp.hold_r",  32'(r),         32'h00F0);
        check_eq("bp.hold_v",  32'(out_valid), 32'h1);
        check_eq("bp.hold_br", 32'(br),        32'h0000);
        out_ready = 1'b1;
        #1;
        check_eq("bp.ready_up", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("bp.br",      32'(br),        32'h00F0);
        check_eq("bp.next_r",  32'(r),         32'h0003);
        check_eq("bp.next_v",  32'(out_valid), 32'h1);
        consume();
        check_eq("bp.next_br", 32'(br),        32'h0003);

        // Back-to-back throughput with out_ready held high
        out_ready = 1'b1; src_sel = 1'b0; src_a = {16'h0000, 16'h0001}; b = 16'h0001;
        op = 4'd0; in_valid = 1'b1;
        tick();
        check_eq("b2b.r1",    32'(r),        32'h0002);
        check_eq("b2b.ready", 32'(in_ready), 32'h1);
        src_a = {16'h0000, 16'h0002}; b = 16'h0002;
        tick();
        in_valid = 1'b0;
        check_eq("b2b.r2",    32'(r),         32'h0004);
        check_eq("b2b.br1",   32'(br),        32'h0002);
        check_eq("b2b.valid", 32'(out_valid), 32'h1);
        tick();
        out_ready = 1'b0;
        check_eq("b2b.br2",   32'(br),        32'h0004);
        check_eq("b2b.drop",  32'(out_valid), 32'h0);

        op_case("sra",     1'b0, 16'h8001, 16'h0000, 16'h0011, 4'd8,  16'hC000, 1'b0, 1'b0, 1'b0);
        op_case("srl",     1'b0, 16'h8001, 16'h0000, 16'h0001, 4'd7,  16'h4000, 1'b0, 1'b0, 1'b0);
        op_case("srl4",    1'b0, 16'h8001, 16'h0000, 16'h0004, 4'd7,  16'h0800, 1'b0, 1'b0, 1'b0);
        op_case("sll",     1'b0, 16'h8001, 16'h0000, 16'h0001, 4'd6,  16'h0002, 1'b0, 1'b0, 1'b0);
        op_case("ill13",   1'b0, 16'h8001, 16'h0000, 16'h0001, 4'd13, 16'h0000, 1'b1, 1'b0, 1'b1);
        op_case("or",      1'b0, 16'h1200, 16'h0000, 16'h0034, 4'd3,  16'h1234, 1'b0, 1'b0, 1'b0);
        op_case("xor",     1'b0, 16'hAAAA, 16'h0000, 16'hFFFF, 4'd4,  16'h5555, 1'b0, 1'b0, 1'b0);
        op_case("not",     1'b0, 16'h00FF, 16'h0000, 16'h1234, 4'd5,  16'hFF00, 1'b0, 1'b0, 1'b0);
        op_case("slt_t",   1'b0, 16'hFFFF, 16'h0000, 16'h0001, 4'd9,  16'h0001, 1'b0, 1'b0, 1'b0);
        op_case("slt_f",   1'b0, 16'h0001, 16'h0000, 16'hFFFF, 4'd9,  16'h0000, 1'b1, 1'b0, 1'b0);
        op_case("add_wrap",1'b0, 16'h8000, 16'h0000, 16'h8000, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0);
        op_case("sub_ovf", 1'b0, 16'h8000, 16'h0000, 16'h0001, 4'd1,  16'h7FFF, 1'b0, 1'b1, 1'b0);
        op_case("sub_neg", 1'b0, 16'h0003, 16'h0000, 16'h0005, 4'd1,  16'hFFFE, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SYSTEM_MUL_EN
        mul_case("mul_neg", 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0);
        mul_case("mul_ovf", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        mul_case("mul_min", 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1);

        // Async reset in the middle of a multiply
        issue(1'b0, 16'h0003, 16'h0000, 16'h0003, 4'd10);
        repeat (5) tick();
        check_eq("arst.busy", 32'(in_ready), 32'h0);
        #2 reset = 1'b0;
        #1;
`else
        op_case("mul_ill", 1'b0, 16'h0003, 16'h0000, 16'h0003, 4'd10, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Async reset with a stalled result in the output register
        issue(1'b0, 16'h7000, 16'h0000, 16'hFFFF, 4'd2);
        check_eq("arst.pre_r", 32'(r), 32'h7000);
        #2 reset = 1'b0;
        #1;
`endif
        check_eq("arst.r",        32'(r),         32'h0);
        check_eq("arst.br",       32'(br),        32'h0);
        check_eq("arst.valid",    32'(out_valid), 32'h0);
        check_eq("arst.zero",     32'(zero),      32'h0);
        check_eq("arst.ovfl",     32'(ovfl),      32'h0);
        check_eq("arst.illegal",  32'(illegal),   32'h0);
        check_eq("arst.in_ready", 32'(in_ready),  32'h1);
        tick();
        reset = 1'b1;
        #1;
        check_eq("arst.rel_ready", 32'(in_ready), 32'h1);
        op_case("post_add", 1'b0, 16'h0002, 16'h0000, 16'h0003, 4'd0, 16'h0005, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
